// File: rtl/fir_datapath_mc_if.sv
// Valid/ready stream bundle: one data word plus byte strobes, with producer (master)
// and consumer (slave) views.
interface fir_datapath_mc_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    localparam int unsigned STRB_WIDTH = (DATA_WIDTH + 7) / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport master (output valid, output data, output strb, input ready);
    modport slave  (input valid, input data, input strb, output ready);
endinterface

// File: rtl/fir_datapath_mc.sv
// Time-interleaved multi-channel direct-form FIR: one shared coefficient set, one delay
// line per channel, runtime tap count, rounding right-shift with saturation, decimation.
module fir_datapath_mc #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned NB_TAPS     = 50,
    parameter int unsigned NB_CHANNELS = 4,
    parameter int unsigned DECIM_WIDTH = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            clear_i,
    input  logic [$clog2(NB_TAPS+1)-1:0]    nb_taps_i,
    input  logic [$clog2(2*DATA_WIDTH)-1:0] shift_i,
    input  logic [DECIM_WIDTH-1:0]          decim_i,
    output logic                            coeff_loaded_o,
    fir_datapath_mc_if.slave                x,
    fir_datapath_mc_if.slave                h,
    fir_datapath_mc_if.master               y
);
    localparam int unsigned TW     = $clog2(NB_TAPS + 1);
    localparam int unsigned SW     = $clog2(2 * DATA_WIDTH);
    localparam int unsigned CW     = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1;
    localparam int unsigned PW     = 2 * DATA_WIDTH;
    localparam int unsigned AW     = 2 * DATA_WIDTH + $clog2(NB_TAPS);
    localparam int unsigned STRB_W = (DATA_WIDTH + 7) / 8;

    // Output clamp bounds at rounded-accumulator width (one guard bit above AW).
    localparam logic signed [AW:0] SAT_MAX = {{(AW - DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [AW:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [0:0] {
        LOAD_H,
        RUN
    } state_e;

    state_e                       state_reg;
    state_e                       state_next;
    logic [TW-1:0]                nb_taps_reg;
    logic [SW-1:0]                shift_reg;
    logic [DECIM_WIDTH-1:0]       decim_reg;
    logic [CW-1:0]                ch_cnt_reg;
    logic [DECIM_WIDTH-1:0]       phase_cnt_reg;
    logic signed [DATA_WIDTH-1:0] line_reg   [NB_CHANNELS][NB_TAPS];
    logic signed [DATA_WIDTH-1:0] line_shift [NB_TAPS];
    logic signed [PW-1:0]         prod_all   [NB_TAPS];
    logic                         s1_valid_reg;
    logic                         s1_out_en_reg;
    logic                         y_valid_reg;
    logic [DATA_WIDTH-1:0]        y_data_reg;

    logic                         enable;
    logic                         x_ready;
    logic                         h_ready;
    logic                         x_hs;
    logic                         h_hs;
    logic signed [AW-1:0]         acc_sum;
    logic signed [AW:0]           acc_rnd;
    logic signed [AW:0]           acc_shr;
    logic [DATA_WIDTH-1:0]        sat_val;

    assign enable  = ~y_valid_reg | y.ready;
    assign x_hs    = x.valid & x_ready;
    assign h_hs    = h.valid & h_ready;
    assign x.ready = x_ready;
    assign h.ready = h_ready;
    assign y.valid = y_valid_reg;
    assign y.data  = y_data_reg;
    assign y.strb  = {STRB_W{y_valid_reg}};

    assign coeff_loaded_o = (state_reg == RUN);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= LOAD_H;
        end else begin
            state_reg <= state_next;
        end
    end

    // A clear beat is never transferred, so both readies drop while clear_i is high.
    always_comb begin
        state_next = state_reg;
        h_ready    = 1'b0;
        x_ready    = 1'b0;
        if (clear_i) begin
            state_next = LOAD_H;
        end else begin
            case (state_reg)
                LOAD_H: begin
                    h_ready = rst_ni;
                    if (h.valid && rst_ni) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    x_ready = enable;
                end
                default: begin
                    state_next = LOAD_H;
                end
            endcase
        end
    end

    // Sampled configuration, normalised once so the datapath never sees illegal values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            nb_taps_reg <= '0;
            shift_reg   <= '0;
            decim_reg   <= '0;
        end else if (h_hs) begin
            nb_taps_reg <= (nb_taps_i > TW'(NB_TAPS)) ? TW'(NB_TAPS) : nb_taps_i;
            shift_reg   <= shift_i;
            decim_reg   <= (decim_i == '0) ? DECIM_WIDTH'(1) : decim_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ch_cnt_reg    <= '0;
            phase_cnt_reg <= '0;
        end else if (clear_i) begin
            ch_cnt_reg    <= '0;
            phase_cnt_reg <= '0;
        end else if (x_hs) begin
            if (ch_cnt_reg == CW'(NB_CHANNELS - 1)) begin
                ch_cnt_reg <= '0;
                if (phase_cnt_reg >= decim_reg - DECIM_WIDTH'(1)) begin
                    phase_cnt_reg <= '0;
                end else begin
                    phase_cnt_reg <= phase_cnt_reg + DECIM_WIDTH'(1);
                end
            end else begin
                ch_cnt_reg <= ch_cnt_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NB_CHANNELS; c++) begin
                for (int k = 0; k < NB_TAPS; k++) begin
                    line_reg[c][k] <= '0;
                end
            end
        end else if (clear_i) begin
            for (int c = 0; c < NB_CHANNELS; c++) begin
                for (int k = 0; k < NB_TAPS; k++) begin
                    line_reg[c][k] <= '0;
                end
            end
        end else if (x_hs) begin
            for (int c = 0; c < NB_CHANNELS; c++) begin
                if (ch_cnt_reg == CW'(c)) begin
                    for (int k = 0; k < NB_TAPS; k++) begin
                        line_reg[c][k] <= line_shift[k];
                    end
                end
            end
        end
    end

    // Per tap: the post-shift view of the active channel's line, the stored coefficient
    // and the stage-1 product register.
    for (genvar gi = 0; gi < NB_TAPS; gi++) begin : g_tap
        logic signed [DATA_WIDTH-1:0] coeff_reg;
        logic signed [PW-1:0]         prod_reg;
        logic                         tap_en;

        if (gi == 0) begin : g_head
            assign line_shift[gi] = x.data;
        end else begin : g_body
            assign line_shift[gi] = line_reg[ch_cnt_reg][gi-1];
        end

        assign tap_en       = (TW'(gi) < nb_taps_reg);
        assign prod_all[gi] = prod_reg;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                coeff_reg <= '0;
            end else if (h_hs) begin
                coeff_reg <= h.data[gi*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                prod_reg <= '0;
            end else if (x_hs) begin
                if (tap_en) begin
                    prod_reg <= coeff_reg * line_shift[gi];
                end else begin
                    prod_reg <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_reg  <= 1'b0;
            s1_out_en_reg <= 1'b0;
        end else if (clear_i) begin
            s1_valid_reg  <= 1'b0;
            s1_out_en_reg <= 1'b0;
        end else if (enable) begin
            s1_valid_reg <= x_hs;
            if (x_hs) begin
                s1_out_en_reg <= (phase_cnt_reg == '0);
            end
        end
    end

    // Reduction, round-half-up, arithmetic shift, clamp.
    always_comb begin
        acc_sum = '0;
        for (int k = 0; k < NB_TAPS; k++) begin
            acc_sum = acc_sum + AW'(prod_all[k]);
        end
        acc_rnd = (AW+1)'(acc_sum);
        if (shift_reg != '0) begin
            acc_rnd = acc_rnd + $signed((AW+1)'(1) << (shift_reg - SW'(1)));
        end
        acc_shr = acc_rnd >>> shift_reg;
        if (acc_shr > SAT_MAX) begin
            sat_val = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
        end else if (acc_shr < SAT_MIN) begin
            sat_val = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
        end else begin
            sat_val = acc_shr[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            y_valid_reg <= 1'b0;
            y_data_reg  <= '0;
        end else if (clear_i) begin
            y_valid_reg <= 1'b0;
        end else if (enable) begin
            y_valid_reg <= s1_valid_reg & s1_out_en_reg;
            if (s1_valid_reg && s1_out_en_reg) begin
                y_data_reg <= sat_val;
            end
        end
    end
endmodule
